// File: rtl/age_ordered_issue_select.sv
// Age-matrix issue selector: picks up to ISSUE_WIDTH oldest ready queue entries
// each cycle and holds them on registered per-port grants until the FU accepts.
module age_ordered_issue_select #(
  parameter int unsigned QUEUE_SIZE  = 16,
  parameter int unsigned QUEUE_INDEX = 4,
  parameter int unsigned ISSUE_WIDTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alloc_valid,
  input  logic [QUEUE_INDEX-1:0]             alloc_index,
  input  logic [QUEUE_SIZE-1:0]              entry_ready,
  input  logic                               flush_valid,
  input  logic [QUEUE_SIZE-1:0]              flush_mask,
  input  logic [ISSUE_WIDTH-1:0]             fu_ready,
  output logic [ISSUE_WIDTH-1:0]             grant_valid,
  output logic [ISSUE_WIDTH*QUEUE_INDEX-1:0] grant_index,
  output logic [ISSUE_WIDTH-1:0]             dealloc_valid,
  output logic [ISSUE_WIDTH*QUEUE_INDEX-1:0] dealloc_index,
  output logic [QUEUE_SIZE-1:0]              occupied
);

  localparam int unsigned RANK_W = QUEUE_INDEX + 1;

  // older_q[i][j] set means entry i was allocated before entry j
  logic [QUEUE_SIZE-1:0]              older_q [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]              older_d [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0]              flush_vec;
  logic [QUEUE_SIZE-1:0]              alloc_vec;
  logic [QUEUE_SIZE-1:0]              pending;
  logic [QUEUE_SIZE-1:0]              freed;
  logic [QUEUE_SIZE-1:0]              cand;
  logic [QUEUE_SIZE-1:0]              occupied_d;
  logic [RANK_W-1:0]                  rank [QUEUE_SIZE];
  logic [RANK_W-1:0]                  load_slot;
  logic [ISSUE_WIDTH-1:0]             grant_valid_d;
  logic [ISSUE_WIDTH*QUEUE_INDEX-1:0] grant_index_d;

  assign flush_vec     = flush_valid ? flush_mask : '0;
  assign dealloc_valid = grant_valid & fu_ready;
  assign dealloc_index = grant_index;

  // Entries sitting in a port register, and those handed to an FU this cycle
  always_comb begin : pending_freed
    pending = '0;
    freed   = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      if (grant_valid[p])   pending[grant_index[p*QUEUE_INDEX +: QUEUE_INDEX]] = 1'b1;
      if (dealloc_valid[p]) freed[grant_index[p*QUEUE_INDEX +: QUEUE_INDEX]]   = 1'b1;
    end
  end

  assign cand = occupied & entry_ready & ~pending & ~flush_vec;

  // Rank = number of older candidates; ranks of candidates are unique
  always_comb begin : rank_calc
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      rank[i] = '0;
      for (int j = 0; j < QUEUE_SIZE; j++) begin
        if (cand[j] && older_q[j][i]) rank[i] = rank[i] + RANK_W'(1);
      end
    end
  end

  // Loading ports take candidates in age order; stalled ports hold unless flushed
  always_comb begin : port_load
    grant_valid_d = grant_valid;
    grant_index_d = grant_index;
    load_slot     = '0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      if (!grant_valid[p] || dealloc_valid[p]) begin
        grant_valid_d[p] = 1'b0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
          if (cand[i] && (rank[i] == load_slot)) begin
            grant_valid_d[p]                            = 1'b1;
            grant_index_d[p*QUEUE_INDEX +: QUEUE_INDEX] = QUEUE_INDEX'(i);
          end
        end
        load_slot = load_slot + RANK_W'(1);
      end else if (flush_vec[grant_index[p*QUEUE_INDEX +: QUEUE_INDEX]]) begin
        grant_valid_d[p] = 1'b0;
      end
    end
  end

  // New entry is younger than everything currently occupied; alloc beats flush
  always_comb begin : age_update
    alloc_vec = '0;
    for (int j = 0; j < QUEUE_SIZE; j++) begin
      older_d[j] = older_q[j];
      if (alloc_valid) begin
        if (alloc_index == QUEUE_INDEX'(j)) alloc_vec[j] = 1'b1;
        older_d[j][alloc_index] = (alloc_index == QUEUE_INDEX'(j)) ? 1'b0 : occupied[j];
      end
    end
    if (alloc_valid) older_d[alloc_index] = '0;
    occupied_d = (occupied & ~freed & ~flush_vec) | alloc_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupied    <= '0;
      grant_valid <= '0;
      grant_index <= '0;
      for (int i = 0; i < QUEUE_SIZE; i++) older_q[i] <= '0;
    end else begin
      occupied    <= occupied_d;
      grant_valid <= grant_valid_d;
      grant_index <= grant_index_d;
      for (int i = 0; i < QUEUE_SIZE; i++) older_q[i] <= older_d[i];
    end
  end

endmodule

// File: tb/tb_age_ordered_issue_select.sv
// Directed bench for age_ordered_issue_select with hand-computed expectations.
module tb_age_ordered_issue_select;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  alloc_index;
  logic [15:0] entry_ready;
  logic        flush_valid;
  logic [15:0] flush_mask;
  logic [1:0]  fu_ready;
  logic [1:0]  grant_valid;
  logic [7:0]  grant_index;
  logic [1:0]  dealloc_valid;
  logic [7:0]  dealloc_index;
  logic [15:0] occupied;
  logic [3:0]  g0, g1;

  int checks = 0;
  int errors = 0;

  age_ordered_issue_select #(.QUEUE_SIZE(16), .QUEUE_INDEX(4), .ISSUE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_index(alloc_index),
    .entry_ready(entry_ready), .flush_valid(flush_valid), .flush_mask(flush_mask),
    .fu_ready(fu_ready), .grant_valid(grant_valid), .grant_index(grant_index),
    .dealloc_valid(dealloc_valid), .dealloc_index(dealloc_index), .occupied(occupied)
  );

  assign g0 = grant_index[3:0];
  assign g1 = grant_index[7:4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && alloc_valid) begin
      assert (!occupied[alloc_index]) else $error("illegal alloc to occupied entry %0d", alloc_index);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input int idx);
    alloc_valid = 1'b1;
    alloc_index = 4'(idx);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (grant_valid !== 2'b00) begin errors++; $display("FAIL reset_gv got %b exp 00", grant_valid); end
    checks++; if (grant_index !== 8'h00) begin errors++; $display("FAIL reset_gi got %h exp 00", grant_index); end
    checks++; if (occupied !== 16'h0000) begin errors++; $display("FAIL reset_occ got %h exp 0000", occupied); end
    checks++; if (dealloc_valid !== 2'b00) begin errors++; $display("FAIL reset_dv got %b exp 00", dealloc_valid); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    fu_ready = 2'b11;
    entry_ready = 16'h0000;
    do_alloc(5);
    do_alloc(2);
    do_alloc(9);
    entry_ready = 16'hFFFF;
    tick();
    checks++; if (grant_valid !== 2'b11 || g0 !== 4'd5 || g1 !== 4'd2) begin errors++;
      $display("FAIL basic_first got v=%b g0=%0d g1=%0d exp v=11 g0=5 g1=2", grant_valid, g0, g1); end
    checks++; if (dealloc_valid !== 2'b11 || dealloc_index !== 8'h25) begin errors++;
      $display("FAIL basic_dealloc got v=%b idx=%h exp v=11 idx=25", dealloc_valid, dealloc_index); end
    tick();
    checks++; if (grant_valid !== 2'b01 || g0 !== 4'd9) begin errors++;
      $display("FAIL basic_second got v=%b g0=%0d exp v=01 g0=9", grant_valid, g0); end
    checks++; if (occupied !== 16'h0200) begin errors++; $display("FAIL basic_occ got %h exp 0200", occupied); end
    tick();
    checks++; if (grant_valid !== 2'b00 || occupied !== 16'h0000) begin errors++;
      $display("FAIL basic_empty got v=%b occ=%h exp v=00 occ=0000", grant_valid, occupied); end
    checks++; if (dealloc_valid !== 2'b00) begin errors++; $display("FAIL basic_no_dealloc got %b exp 00", dealloc_valid); end
  endtask

  task automatic test_stall();
    fu_ready = 2'b10;
    entry_ready = 16'h0000;
    do_alloc(5);
    do_alloc(2);
    do_alloc(9);
    entry_ready = 16'hFFFF;
    tick();
    checks++; if (grant_valid !== 2'b11 || g0 !== 4'd5 || g1 !== 4'd2) begin errors++;
      $display("FAIL stall_load got v=%b g0=%0d g1=%0d exp v=11 g0=5 g1=2", grant_valid, g0, g1); end
    tick();
    checks++; if (grant_valid !== 2'b11 || g0 !== 4'd5 || g1 !== 4'd9) begin errors++;
      $display("FAIL stall_hold got v=%b g0=%0d g1=%0d exp v=11 g0=5 g1=9", grant_valid, g0, g1); end
    tick();
    checks++; if (grant_valid !== 2'b01 || g0 !== 4'd5 || occupied !== 16'h0020) begin errors++;
      $display("FAIL stall_drain got v=%b g0=%0d occ=%h exp v=01 g0=5 occ=0020", grant_valid, g0, occupied); end
    fu_ready = 2'b01;
    tick();
    checks++; if (grant_valid !== 2'b00 || occupied !== 16'h0000) begin errors++;
      $display("FAIL stall_release got v=%b occ=%h exp v=00 occ=0000", grant_valid, occupied); end
  endtask

  task automatic test_wrap();
    fu_ready = 2'b00;
    entry_ready = 16'h0000;
    do_alloc(14);
    do_alloc(15);
    do_alloc(0);
    do_alloc(1);
    entry_ready = 16'h8001;
    tick();
    checks++; if (grant_valid !== 2'b11 || g0 !== 4'd15 || g1 !== 4'd0) begin errors++;
      $display("FAIL wrap_order got v=%b g0=%0d g1=%0d exp v=11 g0=15 g1=0", grant_valid, g0, g1); end
    fu_ready = 2'b11;
    tick();
    checks++; if (grant_valid !== 2'b00 || occupied !== 16'h4002) begin errors++;
      $display("FAIL wrap_fire got v=%b occ=%h exp v=00 occ=4002", grant_valid, occupied); end
    entry_ready = 16'hFFFF;
    tick();
    checks++; if (grant_valid !== 2'b11 || g0 !== 4'd14 || g1 !== 4'd1) begin errors++;
      $display("FAIL wrap_rest got v=%b g0=%0d g1=%0d exp v=11 g0=14 g1=1", grant_valid, g0, g1); end
    tick();
    checks++; if (occupied !== 16'h0000) begin errors++; $display("FAIL wrap_clear got %h exp 0000", occupied); end
    fu_ready = 2'b00;
  endtask

  task automatic test_flush();
    fu_ready = 2'b00;
    entry_ready = 16'h0000;
    do_alloc(3);
    do_alloc(7);
    entry_ready = 16'h0088;
    tick();
    checks++; if (grant_valid !== 2'b11 || g0 !== 4'd3 || g1 !== 4'd7) begin errors++;
      $display("FAIL flush_setup got v=%b g0=%0d g1=%0d exp v=11 g0=3 g1=7", grant_valid, g0, g1); end
    flush_valid = 1'b1;
    flush_mask = 16'h0080;
    tick();
    flush_valid = 1'b0;
    flush_mask = 16'h0000;
    checks++; if (grant_valid !== 2'b01 || g0 !== 4'd3 || occupied !== 16'h0008) begin errors++;
      $display("FAIL flush_drop got v=%b g0=%0d occ=%h exp v=01 g0=3 occ=0008", grant_valid, g0, occupied); end
    tick();
    checks++; if (grant_valid !== 2'b01) begin errors++; $display("FAIL flush_no_regrant got %b exp 01", grant_valid); end
    fu_ready = 2'b01;
    tick();
    checks++; if (occupied !== 16'h0000 || grant_valid !== 2'b00) begin errors++;
      $display("FAIL flush_cleanup got v=%b occ=%h exp v=00 occ=0000", grant_valid, occupied); end
    fu_ready = 2'b00;
  endtask

  task automatic test_fire_flush();
    fu_ready = 2'b00;
    entry_ready = 16'h0010;
    do_alloc(4);
    tick();
    checks++; if (grant_valid !== 2'b01 || g0 !== 4'd4) begin errors++;
      $display("FAIL ff_grant got v=%b g0=%0d exp v=01 g0=4", grant_valid, g0); end
    fu_ready = 2'b01;
    flush_valid = 1'b1;
    flush_mask = 16'h0010;
    #1;
    checks++; if (dealloc_valid !== 2'b01 || dealloc_index[3:0] !== 4'd4) begin errors++;
      $display("FAIL ff_dealloc got v=%b idx=%0d exp v=01 idx=4", dealloc_valid, dealloc_index[3:0]); end
    tick();
    flush_valid = 1'b0;
    flush_mask = 16'h0000;
    checks++; if (occupied !== 16'h0000 || grant_valid !== 2'b00) begin errors++;
      $display("FAIL ff_freed got v=%b occ=%h exp v=00 occ=0000", grant_valid, occupied); end
    tick();
    checks++; if (grant_valid !== 2'b00) begin errors++; $display("FAIL ff_no_regrant got %b exp 00", grant_valid); end
    fu_ready = 2'b00;
  endtask

  task automatic test_alloc_flush();
    entry_ready = 16'h0000;
    fu_ready = 2'b00;
    do_alloc(12);
    flush_valid = 1'b1;
    flush_mask = 16'h0800;
    do_alloc(11);
    flush_valid = 1'b0;
    flush_mask = 16'h0000;
    checks++; if (occupied !== 16'h1800) begin errors++; $display("FAIL af_occ got %h exp 1800", occupied); end
    entry_ready = 16'h1800;
    tick();
    checks++; if (grant_valid !== 2'b11 || g0 !== 4'd12 || g1 !== 4'd11) begin errors++;
      $display("FAIL af_order got v=%b g0=%0d g1=%0d exp v=11 g0=12 g1=11", grant_valid, g0, g1); end
    fu_ready = 2'b11;
    tick();
    checks++; if (occupied !== 16'h0000) begin errors++; $display("FAIL af_clear got %h exp 0000", occupied); end
    fu_ready = 2'b00;
  endtask

  task automatic test_full();
    entry_ready = 16'h0000;
    fu_ready = 2'b11;
    for (int i = 0; i < 16; i++) do_alloc(i);
    checks++; if (occupied !== 16'hFFFF || grant_valid !== 2'b00) begin errors++;
      $display("FAIL full_state got v=%b occ=%h exp v=00 occ=ffff", grant_valid, occupied); end
    tick();
    checks++; if (occupied !== 16'hFFFF || grant_valid !== 2'b00) begin errors++;
      $display("FAIL full_hold got v=%b occ=%h exp v=00 occ=ffff", grant_valid, occupied); end
    entry_ready = 16'h0100;
    tick();
    checks++; if (grant_valid !== 2'b01 || g0 !== 4'd8) begin errors++;
      $display("FAIL full_single got v=%b g0=%0d exp v=01 g0=8", grant_valid, g0); end
    entry_ready = 16'h0000;
    flush_valid = 1'b1;
    flush_mask = 16'hFFFF;
    tick();
    flush_valid = 1'b0;
    flush_mask = 16'h0000;
    checks++; if (occupied !== 16'h0000 || grant_valid !== 2'b00) begin errors++;
      $display("FAIL full_flush got v=%b occ=%h exp v=00 occ=0000", grant_valid, occupied); end
    fu_ready = 2'b00;
  endtask

  task automatic test_reset_midstream();
    fu_ready = 2'b00;
    entry_ready = 16'h0000;
    do_alloc(8);
    do_alloc(10);
    entry_ready = 16'h0500;
    tick();
    checks++; if (grant_valid !== 2'b11 || g0 !== 4'd8 || g1 !== 4'd10) begin errors++;
      $display("FAIL mid_setup got v=%b g0=%0d g1=%0d exp v=11 g0=8 g1=10", grant_valid, g0, g1); end
    rst = 1'b1;
    alloc_valid = 1'b1;
    alloc_index = 4'd3;
    fu_ready = 2'b11;
    tick();
    rst = 1'b0;
    alloc_valid = 1'b0;
    fu_ready = 2'b00;
    checks++; if (grant_valid !== 2'b00 || occupied !== 16'h0000) begin errors++;
      $display("FAIL mid_reset got v=%b occ=%h exp v=00 occ=0000", grant_valid, occupied); end
    entry_ready = 16'h0040;
    do_alloc(6);
    checks++; if (grant_valid !== 2'b00 || occupied !== 16'h0040) begin errors++;
      $display("FAIL mid_alloc got v=%b occ=%h exp v=00 occ=0040", grant_valid, occupied); end
    tick();
    checks++; if (grant_valid !== 2'b01 || g0 !== 4'd6) begin errors++;
      $display("FAIL mid_regrant got v=%b g0=%0d exp v=01 g0=6", grant_valid, g0); end
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 1'b0;
    alloc_index = 4'd0;
    entry_ready = 16'h0000;
    flush_valid = 1'b0;
    flush_mask = 16'h0000;
    fu_ready = 2'b00;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_flush();
    test_fire_flush();
    test_alloc_flush();
    test_full();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/age_ordered_issue_select.md
Name: age_ordered_issue_select

Overview:
- Parametrised multi-port successor to the single-port bottom-up dispatch selector used by the integer/memory issue queues.
- Tracks relative age of occupied queue entries with an age matrix.
- Each cycle, selects up to ISSUE_WIDTH oldest ready entries and presents them on registered per-port grant outputs with a valid/ready handshake to the functional units.
- Supports partial squash through a flush mask; sits between an issue queue and its ALU/AGU ports.

Parameters:
QUEUE_SIZE, 16, number of issue-queue entries tracked
QUEUE_INDEX, 4, index width, equals clog2(QUEUE_SIZE)
ISSUE_WIDTH, 2, number of independent issue ports (1..4)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
alloc_valid  input  1  allocate entry alloc_index this cycle
alloc_index  input  QUEUE_INDEX  entry being allocated; must be unoccupied
entry_ready  input  QUEUE_SIZE  per-entry operands-ready from the queue
flush_valid  input  1  squash entries in flush_mask
flush_mask  input  QUEUE_SIZE  entries to squash
fu_ready  input  ISSUE_WIDTH  per-port functional unit can accept
grant_valid  output  ISSUE_WIDTH  registered: port p holds an issued entry
grant_index  output  ISSUE_WIDTH*QUEUE_INDEX  registered: entry on port p; slice p at [p*QUEUE_INDEX +: QUEUE_INDEX]
dealloc_valid  output  ISSUE_WIDTH  combinational: port p fires (grant_valid[p] & fu_ready[p])
dealloc_index  output  ISSUE_WIDTH*QUEUE_INDEX  equals grant_index; queue frees this entry
occupied  output  QUEUE_SIZE  registered occupancy vector

Behaviour:
- Reset (rst=1 at edge):
  - occupied = 0
  - age matrix = 0
  - grant_valid = 0
  - grant_index = 0
  - Reset overrides alloc, flush and fire in the same cycle.
- Age matrix older[i][j] (i older than j):
  - On alloc of k: older[k][*] = 0; older[j][k] = occupied[j] for all j ≠ k.
  - older[k][k] always 0.
  - Rows and columns of freed entries are don't-care; they are masked by occupied.
- Pending set: an entry is pending if it sits in any port register with grant_valid set.
- Candidates: cand[i] = occupied[i] & entry_ready[i] & !pending[i] & !(flush_valid & flush_mask[i]).
  - An entry allocated this cycle is not a candidate until next cycle.
- Rank: rank[i] = number of candidates j with older[j][i].
- Port loading: port p loads when !grant_valid[p] or dealloc_valid[p].
  - Loading ports are numbered in ascending port order as l = 0,1,...
  - The candidate with rank l is loaded into the l-th loading port (grant_valid = 1, grant_index = i).
  - A loading port with no rank-l candidate takes grant_valid = 0.
  - A non-loading port holds its grant_valid and grant_index unchanged (stall).
- Latency:
  - Entry ready in cycle t with a free port: grant_valid at t+1.
  - Allocated in cycle t and ready: earliest grant at t+2.
- Fire on port p: occupied[grant_index[p]] cleared at the next edge.
- Flush:
  - occupied[i] cleared for every masked i.
  - A port whose held grant_index is masked drops grant_valid next cycle, unless it fires this cycle.
  - Fire and flush on the same entry: the handshake completes, dealloc is asserted, and the entry is freed once.
- Alloc plus flush of the same index in one cycle: alloc wins; the entry ends up occupied as the youngest.
- Alloc to an occupied index is illegal; the bench asserts against it.
- Wrap-around: age ordering is independent of index order. After index 15, an alloc to index 0 is younger than all occupied entries.
- Empty queue or no candidates: loading ports go invalid; no spurious dealloc.
- Full queue (all occupied, none ready): no grants; state holds.

Test Plan:
- Reset then alloc 5, 2, 9 on consecutive cycles, all entry_ready=1 from the cycle after the last alloc, fu_ready=11 → next cycle grant0=5, grant1=2; following cycle grant0=9, grant1 invalid.
- Port 0 stalled (fu_ready=10) holding entry 5, entries 2 and 9 ready → port 0 keeps 5 each cycle; port 1 issues 2 then 9; entry 5 never issued twice.
- Alloc indices 14, 15, 0, 1 (wrap) with only 0 and 15 ready → grant0=15, grant1=0 (age order, not index order).
- Ports holding 3 and 7 with fu_ready=00, flush_mask=0x0080 → next cycle port1 invalid, port0 still 3; occupied[7]=0.
- Port0 holding 4, fu_ready[0]=1, flush_mask bit 4 set in the same cycle → dealloc_valid[0]=1 with index 4; occupied[4]=0 next cycle; no re-grant.
- rst asserted mid-stream with two grants pending → next cycle grant_valid=00, occupied=0; a fresh alloc of 6 (ready) is granted on port 0 two cycles later.
